// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg: shared types and defaults for the main memory controller.
//   mem_state_t    : controller state (INIT = post-reset clear, READY = service)
//   MEM_DATA_W_DEF : default word width in bits
//   MEM_ADDR_W_DEF : default byte-address width
//   mem_rsp_t      : response record {valid, err, rdata} at the default width
// -----------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } mem_state_t;

    localparam int MEM_DATA_W_DEF = 16;
    localparam int MEM_ADDR_W_DEF = 16;

    typedef struct packed {
        logic                      valid;
        logic                      err;
        logic [MEM_DATA_W_DEF-1:0] rdata;
    } mem_rsp_t;

endpackage

// File: rtl/mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_ctrl_if: request/response channel between the pipeline memory stage
// (master) and the memory controller (slave).
//   req_valid/req_ready : request handshake, accepted when both are high
//   req_write           : 1 = write, 0 = read
//   req_addr            : byte address (ADDR_W bits)
//   req_wdata/req_be    : write data and per-byte lane enables
//   rsp_valid           : one-cycle response strobe
//   rsp_rdata/rsp_err   : read data and misaligned-access flag
// -----------------------------------------------------------------------------
interface mem_ctrl_if
    import mem_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W_DEF,
    parameter int ADDR_W = MEM_ADDR_W_DEF
) ();

    localparam int BYTES = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BYTES-1:0]  req_be;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_byte_bank.sv
// -----------------------------------------------------------------------------
// mem_byte_bank: one 8-bit byte lane of the main memory, 2**IDX_W deep.
//   clk, rst : clock and synchronous active-high reset (read register only)
//   we       : write wdata to word idx at the rising edge
//   rd_en    : capture word idx into the read register
//   rd_clr   : force the read register to zero (error response)
//   idx      : word index shared by the write and read paths
//   wdata    : write byte
//   rdata    : registered read byte; holds its value when neither rd_en nor
//              rd_clr is active
// -----------------------------------------------------------------------------
module mem_byte_bank #(
    parameter int IDX_W = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             rd_en,
    input  logic             rd_clr,
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata
);

    localparam int WORDS = 2 ** IDX_W;

    logic [7:0] mem [WORDS];
    logic [7:0] rd_data_q, rd_data_d;

    // NOTE: the storage array has no reset branch; a reset loop over every
    // word cannot map onto RAM macros, so clearing is done by the controller.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_clr) begin
            rd_data_d = '0;
        end else if (rd_en) begin
            rd_data_d = mem[idx];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rdata = rd_data_q;

endmodule

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl: single-port, byte-addressed, word-organised little-endian main
// memory controller with valid/ready requests, byte-lane writes, a 1-cycle
// registered read and misaligned-access error responses.
//   clk       : clock, all state changes on the rising edge
//   rst       : synchronous active-high reset
//   halt_sys  : global stall; blocks acceptance and freezes the clear sequence
//   bus       : mem_ctrl_if.slave request/response channel
//   init_busy : post-reset clear sequence in progress
// Build option: define MEM_CTRL_CLEAR_ON_RST_EN to zero the whole array after
// every reset (INIT state); otherwise reset goes straight to READY and the
// array keeps its contents.
// -----------------------------------------------------------------------------
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W_DEF,
    parameter int ADDR_W = MEM_ADDR_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       halt_sys,
    mem_ctrl_if.slave  bus,
    output logic       init_busy
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = ADDR_W - OFF_W;
    localparam int WORDS = 2 ** IDX_W;

    mem_state_t        state_q, state_d;
    logic              clr_we;
    logic [IDX_W-1:0]  clr_idx;
    logic              accept;
    logic              aligned;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  bank_idx;
    logic [BYTES-1:0]  bank_we;
    logic [DATA_W-1:0] bank_wdata;
    logic [DATA_W-1:0] rd_data;
    logic              rd_en, rd_clr;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;

`ifdef MEM_CTRL_CLEAR_ON_RST_EN
    logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;

    // Clear sequencer: one word per un-halted cycle, leaving INIT once the
    // last word has been written. rst is excluded so reset never touches data.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        if (state_q == INIT && !halt_sys && !rst) begin
            clr_we    = 1'b1;
            clr_cnt_d = clr_cnt_q + IDX_W'(1);
            if (clr_cnt_q == IDX_W'(WORDS - 1)) begin
                state_d = READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= INIT;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign clr_idx   = clr_cnt_q;
    assign init_busy = (state_q == INIT);
`else
    always_comb begin
        state_d = READY;
        clr_we  = 1'b0;
        clr_idx = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= READY;
        end else begin
            state_q <= state_d;
        end
    end

    assign init_busy = 1'b0;
`endif

    assign bus.req_ready = (state_q == READY) && !halt_sys && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign aligned       = (bus.req_addr[OFF_W-1:0] == '0);
    assign req_idx       = bus.req_addr[ADDR_W-1:OFF_W];

    // NOTE: every signal driven here gets a default first, so no path through
    // the block can leave one unassigned and infer a latch.
    always_comb begin
        bank_idx    = req_idx;
        bank_we     = '0;
        bank_wdata  = bus.req_wdata;
        rd_en       = 1'b0;
        rd_clr      = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        if (clr_we) begin
            bank_idx   = clr_idx;
            bank_we    = '1;
            bank_wdata = '0;
        end else if (accept) begin
            if (!aligned) begin
                // Misaligned: no array access, error response with zero data.
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rd_clr      = 1'b1;
            end else if (bus.req_write) begin
                bank_we = bus.req_be;
            end else begin
                rsp_valid_d = 1'b1;
                rd_en       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    for (genvar k = 0; k < BYTES; k++) begin : g_lane
        mem_byte_bank #(
            .IDX_W (IDX_W)
        ) u_bank (
            .clk    (clk),
            .rst    (rst),
            .we     (bank_we[k]),
            .rd_en  (rd_en),
            .rd_clr (rd_clr),
            .idx    (bank_idx),
            .wdata  (bank_wdata[8*k +: 8]),
            .rdata  (rd_data[8*k +: 8])
        );
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rd_data;

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl: two controllers (16-bit and 32-bit words, 6-bit byte address)
// sharing clk/rst/halt_sys. A byte-addressed reference model predicts ready,
// init_busy and the response of both every cycle; directed sequences pin
// literal values for lane writes, misalignment, halt, reset and throughput.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;
    import mem_pkg::*;

    localparam int AW = 6;
`ifdef MEM_CTRL_CLEAR_ON_RST_EN
    localparam int CLR_EN = 1;
`else
    localparam int CLR_EN = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic halt_sys;
    logic busy16, busy32;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_ctrl_if #(.DATA_W(16), .ADDR_W(AW)) bus16 ();
    mem_ctrl_if #(.DATA_W(32), .ADDR_W(AW)) bus32 ();

    mem_ctrl #(.DATA_W(16), .ADDR_W(AW)) dut16 (
        .clk(clk), .rst(rst), .halt_sys(halt_sys), .bus(bus16), .init_busy(busy16)
    );
    mem_ctrl #(.DATA_W(32), .ADDR_W(AW)) dut32 (
        .clk(clk), .rst(rst), .halt_sys(halt_sys), .bus(bus32), .init_busy(busy32)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (byte-addressed memory) ----------------
    logic [7:0]  m_byte  [2][64];
    bit          m_known [2][64];
    int          m_clr   [2];      // clear cycles still owed
    bit          m_v     [2];
    bit          m_e     [2];
    logic [31:0] m_d     [2];
    logic [3:0]  m_k     [2];      // which response bytes are predictable
    bit          started = 1'b0;

    task automatic model_step(input int d, input bit v, input bit w, input logic [5:0] a,
                              input logic [31:0] wd, input logic [3:0] be);
        int nb    = (d == 0) ? 2 : 4;
        int words = 64 / nb;
        int base;
        if (rst) begin
            m_clr[d] = (CLR_EN != 0) ? words : 0;
            m_v[d] = 1'b0; m_e[d] = 1'b0; m_d[d] = '0; m_k[d] = '1;
            return;
        end
        m_v[d] = 1'b0;
        m_e[d] = 1'b0;
        if (m_clr[d] > 0) begin
            if (!halt_sys) begin
                base = (words - m_clr[d]) * nb;
                for (int b = 0; b < nb; b++) begin
                    m_byte[d][base+b]  = 8'h00;
                    m_known[d][base+b] = 1'b1;
                end
                m_clr[d]--;
            end
        end else if (v && !halt_sys) begin
            if (int'(a) % nb != 0) begin
                m_v[d] = 1'b1; m_e[d] = 1'b1; m_d[d] = '0; m_k[d] = '1;
            end else if (w) begin
                for (int b = 0; b < nb; b++) begin
                    if (be[b]) begin
                        m_byte[d][int'(a)+b]  = wd[8*b +: 8];
                        m_known[d][int'(a)+b] = 1'b1;
                    end
                end
            end else begin
                m_v[d] = 1'b1; m_d[d] = '0; m_k[d] = '1;
                for (int b = 0; b < nb; b++) begin
                    m_d[d][8*b +: 8] = m_byte[d][int'(a)+b];
                    m_k[d][b]        = m_known[d][int'(a)+b];
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, bus16.req_valid, bus16.req_write, bus16.req_addr,
                   32'(bus16.req_wdata), 4'(bus16.req_be));
        model_step(1, bus32.req_valid, bus32.req_write, bus32.req_addr,
                   bus32.req_wdata, bus32.req_be);
        if (rst) started = 1'b1;
    end

    task automatic cmp(input int d, input logic rdy, input logic busy, input logic v,
                       input logic e, input logic [31:0] rd);
        string       n = (d == 0) ? "d16" : "d32";
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{m_k[d][b]}};
        check({n, ".req_ready"}, 32'(rdy), 32'((m_clr[d] == 0) && !halt_sys && !rst));
        check({n, ".init_busy"}, 32'(busy), 32'(m_clr[d] != 0));
        check({n, ".rsp_valid"}, 32'(v), 32'(m_v[d]));
        if (m_v[d]) check({n, ".rsp_err"}, 32'(e), 32'(m_e[d]));
        check({n, ".rsp_rdata"}, rd & mask, m_d[d] & mask);
    endtask

    always @(negedge clk) begin
        if (started) begin
            cmp(0, bus16.req_ready, busy16, bus16.rsp_valid, bus16.rsp_err, 32'(bus16.rsp_rdata));
            cmp(1, bus32.req_ready, busy32, bus32.rsp_valid, bus32.rsp_err, bus32.rsp_rdata);
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until accepted; returns #1 after the
    // accepting edge with req_valid dropped.
    task automatic do16(input bit w, input logic [5:0] a, input logic [15:0] wd, input logic [1:0] be);
        int budget = 200;
        bus16.req_valid = 1'b1; bus16.req_write = w; bus16.req_addr = a;
        bus16.req_wdata = wd;   bus16.req_be = be;
        @(negedge clk);
        while (!bus16.req_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("d16.accept_timeout", 32'(0), 32'(1));
        tick();
        bus16.req_valid = 1'b0;
    endtask

    task automatic do32(input bit w, input logic [5:0] a, input logic [31:0] wd, input logic [3:0] be);
        int budget = 200;
        bus32.req_valid = 1'b1; bus32.req_write = w; bus32.req_addr = a;
        bus32.req_wdata = wd;   bus32.req_be = be;
        @(negedge clk);
        while (!bus32.req_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("d32.accept_timeout", 32'(0), 32'(1));
        tick();
        bus32.req_valid = 1'b0;
    endtask

    // Called #1 after the last edge with rst high; counts cycles to req_ready.
    task automatic measure(input string tag, input int exp16, input int exp32);
        int l16 = 0;
        int l32 = 0;
        for (int n = 1; n <= 100 && (l16 == 0 || l32 == 0); n++) begin
            @(negedge clk);
            if (bus16.req_ready && l16 == 0) begin
                l16 = n;
                check({tag, ".busy16_at_ready"}, 32'(busy16), 32'(0));
            end
            if (bus32.req_ready && l32 == 0) l32 = n;
        end
        check({tag, ".lat16"}, l16, exp16);
        check({tag, ".lat32"}, l32, exp32);
        tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        mem_rsp_t    r16;
        mem_rsp_t    r16_exp;
        bit          acc16, acc32;
        int          guard;
        logic [31:0] b2b_exp;

        rst = 1'b1; halt_sys = 1'b0;
        bus16.req_valid = 1'b0; bus16.req_write = 1'b0; bus16.req_addr = '0;
        bus16.req_wdata = '0;   bus16.req_be = '0;
        bus32.req_valid = 1'b0; bus32.req_write = 1'b0; bus32.req_addr = '0;
        bus32.req_wdata = '0;   bus32.req_be = '0;

        tick(); tick();
        @(negedge clk);
        r16     = '{valid: bus16.rsp_valid, err: bus16.rsp_err, rdata: bus16.rsp_rdata};
        r16_exp = '{valid: 1'b0, err: 1'b0, rdata: 16'h0000};
        check("rst.req_ready", 32'(bus16.req_ready), 32'(0));
        check("rst.rsp16", 32'(r16), 32'(r16_exp));
        check("rst.init_busy", 32'(busy16), 32'(CLR_EN));
        tick();
        rst = 1'b0;
        measure("clear", (CLR_EN != 0) ? 33 : 1, (CLR_EN != 0) ? 17 : 1);

        // Sweep every word; after a clear the model expects zeros.
        for (int i = 0; i < 32; i++) do16(1'b0, 6'(2*i), 16'h0, 2'b00);
`ifdef MEM_CTRL_CLEAR_ON_RST_EN
        @(negedge clk);
        check("clear.last_word", 32'(bus16.rsp_rdata), 32'(16'h0000));
        tick();
`endif

        // Give every word a known value.
        for (int i = 0; i < 32; i++) do16(1'b1, 6'(2*i), 16'($urandom), 2'b11);
        for (int i = 0; i < 16; i++) do32(1'b1, 6'(4*i), $urandom, 4'hF);

        // Byte-lane write.
        do16(1'b1, 6'h04, 16'hBEEF, 2'b11);
        do16(1'b1, 6'h04, 16'h12AA, 2'b01);
        do16(1'b0, 6'h04, 16'h0, 2'b00);
        @(negedge clk);
        check("lane.rsp_valid", 32'(bus16.rsp_valid), 32'(1));
        check("lane.rsp_rdata", 32'(bus16.rsp_rdata), 32'(16'hBEAA));
        check("lane.rsp_err", 32'(bus16.rsp_err), 32'(0));
        tick();

        // Misaligned read and write.
        do16(1'b0, 6'h05, 16'h0, 2'b00);
        @(negedge clk);
        check("misal.rsp_valid", 32'(bus16.rsp_valid), 32'(1));
        check("misal.rsp_err", 32'(bus16.rsp_err), 32'(1));
        check("misal.rsp_rdata", 32'(bus16.rsp_rdata), 32'(0));
        tick();
        do16(1'b1, 6'h06, 16'h5A5A, 2'b11);
        do16(1'b1, 6'h07, 16'hFFFF, 2'b11);
        do16(1'b0, 6'h06, 16'h0, 2'b00);
        @(negedge clk);
        check("misal.word6", 32'(bus16.rsp_rdata), 32'(16'h5A5A));
        tick();

        // Halt right after accepting a read; a held read waits for halt to drop.
        do16(1'b0, 6'h04, 16'h0, 2'b00);
        halt_sys = 1'b1;
        bus16.req_valid = 1'b1; bus16.req_write = 1'b0; bus16.req_addr = 6'h06;
        @(negedge clk);
        check("halt.rsp_valid", 32'(bus16.rsp_valid), 32'(1));
        check("halt.rsp_rdata", 32'(bus16.rsp_rdata), 32'(16'hBEAA));
        check("halt.req_ready", 32'(bus16.req_ready), 32'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("halt.held_ready", 32'(bus16.req_ready), 32'(0));
            check("halt.no_rsp", 32'(bus16.rsp_valid), 32'(0));
        end
        tick();
        halt_sys = 1'b0;
        @(negedge clk);
        check("halt.ready_after", 32'(bus16.req_ready), 32'(1));
        tick();
        bus16.req_valid = 1'b0;
        @(negedge clk);
        check("halt.held_rsp_valid", 32'(bus16.rsp_valid), 32'(1));
        check("halt.held_rsp_rdata", 32'(bus16.rsp_rdata), 32'(16'h5A5A));
        tick();

        // Back-to-back throughput on the 32-bit controller.
        for (int i = 0; i < 8; i++) do32(1'b1, 6'(4*i), 32'hC0DE_0000 + 32'(i) * 32'h0111_0011, 4'hF);
        fork
            begin
                for (int i = 0; i < 8; i++) do32(1'b0, 6'(4*i), 32'h0, 4'h0);
            end
            begin
                guard = 0;
                @(negedge clk);
                while (!bus32.rsp_valid && guard < 50) begin
                    @(negedge clk);
                    guard++;
                end
                check("b2b.start", 32'(guard < 50), 32'(1));
                for (int i = 0; i < 8; i++) begin
                    b2b_exp = 32'hC0DE_0000 + 32'(i) * 32'h0111_0011;
                    check("b2b.rsp_valid", 32'(bus32.rsp_valid), 32'(1));
                    check("b2b.rsp_rdata", bus32.rsp_rdata, b2b_exp);
                    @(negedge clk);
                end
                check("b2b.end", 32'(bus32.rsp_valid), 32'(0));
            end
        join
        tick();

        // Random traffic with random halts; fields are held until accepted.
        acc16 = 1'b0; acc32 = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!bus16.req_valid || acc16) begin
                bus16.req_valid = ($urandom_range(0, 3) != 0);
                bus16.req_write = 1'($urandom_range(0, 1));
                bus16.req_addr  = 6'($urandom_range(0, 63));
                if ($urandom_range(0, 3) != 0) bus16.req_addr[0] = 1'b0;
                bus16.req_wdata = 16'($urandom);
                bus16.req_be    = 2'($urandom);
            end
            if (!bus32.req_valid || acc32) begin
                bus32.req_valid = ($urandom_range(0, 3) != 0);
                bus32.req_write = 1'($urandom_range(0, 1));
                bus32.req_addr  = 6'($urandom_range(0, 63));
                if ($urandom_range(0, 3) != 0) bus32.req_addr[1:0] = 2'b00;
                bus32.req_wdata = $urandom;
                bus32.req_be    = 4'($urandom);
            end
            halt_sys = ($urandom_range(0, 5) == 0);
            @(negedge clk);
            acc16 = bus16.req_valid && bus16.req_ready;
            acc32 = bus32.req_valid && bus32.req_ready;
            tick();
        end
        bus16.req_valid = 1'b0; bus32.req_valid = 1'b0; halt_sys = 1'b0;
        tick();

        // Reset with a response pending and a new read presented.
        do16(1'b0, 6'h04, 16'h0, 2'b00);
        rst = 1'b1;
        bus16.req_valid = 1'b1; bus16.req_write = 1'b0; bus16.req_addr = 6'h06;
        tick();
        @(negedge clk);
        check("rstrd.rsp_valid", 32'(bus16.rsp_valid), 32'(0));
        check("rstrd.rsp_rdata", 32'(bus16.rsp_rdata), 32'(0));
        check("rstrd.req_ready", 32'(bus16.req_ready), 32'(0));
        tick();
        bus16.req_valid = 1'b0;
        rst = 1'b0;

        // Reset again after ten clear cycles: the full clear must repeat.
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        measure("reclear", (CLR_EN != 0) ? 33 : 1, (CLR_EN != 0) ? 17 : 1);
        do16(1'b0, 6'h04, 16'h0, 2'b00);
        @(negedge clk);
        check("reclear.rsp_valid", 32'(bus16.rsp_valid), 32'(1));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Parametrised single-port main memory controller for the CPU data/instruction path: byte-addressed, word-organised, little-endian. It adds a valid/ready request channel, per-byte write enables, a registered read port and a sequential post-reset clear sequencer. Misaligned accesses are reported as errors. It is the drop-in successor for the fixed 16-bit main memory and sits between the pipeline memory stage and the storage array, honouring the global `halt_sys` stall.

## Interface

Parameters:
- `DATA_W`, default 16: word width in bits; must be a multiple of 8 and at least 16.
- `ADDR_W`, default 16: byte-address width.
- Derived (not overridable):
  - `BYTES = DATA_W/8`
  - `OFF_W = $clog2(BYTES)`
  - `WORDS = 2**(ADDR_W-OFF_W)`

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `halt_sys` in 1: global stall.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller accepts the request this cycle.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in `ADDR_W`: byte address.
- `req_wdata` in `DATA_W`: write data; byte k is `[8k+7:8k]`.
- `req_be` in `BYTES`: byte-lane write enables; ignored for reads.
- `rsp_valid` out 1: one-cycle response strobe.
- `rsp_rdata` out `DATA_W`: read data.
- `rsp_err` out 1: misaligned-access flag, qualified by `rsp_valid`.
- `init_busy` out 1: clear sequence in progress.

## Operation

- Handshake:
  - A request is accepted on a cycle where `req_valid && req_ready`.
  - `req_ready = (state==READY) && !halt_sys && !rst`.
  - Requests held while `req_ready` is 0 are not consumed. The requester must hold its request fields stable until acceptance.
- State machine (`mem_state_t`):
  - INIT:
    - Writes zero to word `clr_cnt` each cycle `halt_sys` is low and increments `clr_cnt`.
    - When `clr_cnt == WORDS-1` is written, the machine moves to READY.
    - `halt_sys` freezes `clr_cnt`.
  - READY: services requests; remains here until `rst`.
- Alignment:
  - An access is misaligned if `req_addr[OFF_W-1:0] != 0`.
  - An accepted misaligned access (read or write) performs no array access.
  - It produces `rsp_valid=1`, `rsp_err=1`, `rsp_rdata=0` the next cycle.
- Word index is `req_addr[ADDR_W-1:OFF_W]`.
- Aligned write:
  - Only lanes with `req_be[k]=1` are updated at the accepting edge.
  - `req_be=0` is a legal no-op.
  - No response is generated.
- Aligned read:
  - `rsp_valid=1`, `rsp_err=0`, `rsp_rdata = array[index]` in the next cycle.
  - `rsp_rdata` holds its last value while `rsp_valid=0`.
- Read after write: a read accepted the cycle after a write to the same word returns the new data. The array is updated before the read samples it.
- `halt_sys` blocks new acceptance only. A response for a request accepted in the previous cycle is still delivered while halted.
- Reset (any cycle, including mid-INIT or with a response pending):
  - Next state INIT, `clr_cnt=0`.
  - In-flight response dropped.
  - Array contents are untouched by `rst` itself.

## Timing

- Reset values:
  - `req_ready=0`
  - `rsp_valid=0`
  - `rsp_rdata=0`
  - `rsp_err=0`
  - `init_busy=1` (0 when clear is compiled out)
- Clear latency: exactly `WORDS` un-halted cycles after `rst` deasserts. `req_ready` rises on the following cycle. `init_busy` falls on the same cycle `req_ready` rises.
- Read latency: 1 cycle (accept at edge N, `rsp_valid` high during cycle N+1).
- Throughput: one request per cycle, back-to-back reads give back-to-back responses.

## Configuration

- Macro `MEM_CTRL_CLEAR_ON_RST_EN`.
- Defined: INIT state and `clr_cnt` are present, with behaviour as above.
- Undefined:
  - INIT is compiled out; reset goes directly to READY.
  - `req_ready` is high the first cycle after `rst` deasserts.
  - `init_busy` is tied 0.
  - Array contents are retained across reset and undefined at power-up.

## Structure

- Package `mem_pkg`:
  - `mem_state_t` (INIT, READY)
  - `MEM_DATA_W_DEF = 16`
  - `MEM_ADDR_W_DEF = 16`
  - Response struct `mem_rsp_t` {`valid`, `err`, `rdata`}
- Sub-module `mem_byte_bank`:
  - One 8-bit-wide, `WORDS`-deep lane with write enable, index and registered read.
  - Instantiated `BYTES` times via generate.
  - The top level holds the FSM, clear counter, alignment check and response register.

## Test plan

- Clear sequence, `DATA_W=16`, `ADDR_W=6` (32 words), macro defined:
  - Deassert `rst` → `req_ready` rises exactly 33 cycles later, and `init_busy` falls that same cycle.
  - Every read then returns 0x0000.
- Byte-lane write:
  - Write 0xBEEF to addr 0x04 with `be=2'b11`, then 0x12AA with `be=2'b01`.
  - Read 0x04 next cycle → `rsp_rdata=0xBEAA`, `rsp_err=0`.
- Misaligned access:
  - Read at 0x05 → `rsp_valid=1`, `rsp_err=1`, `rsp_rdata=0`.
  - Write at 0x07 → word 0x06 unchanged.
- Halt:
  - Assert `halt_sys` the cycle after accepting a read of 0x04 → response still delivered.
  - `req_ready=0` while halted; a held request is accepted on the first cycle after `halt_sys` drops.
- Reset mid-INIT and mid-read:
  - Pulse `rst` at `clr_cnt=10` → count restarts at 0, full 32-cycle clear repeats.
  - Pulse `rst` with a read in flight → no `rsp_valid`.
- Back-to-back throughput, `DATA_W=32`:
  - 8 consecutive aligned reads → 8 consecutive `rsp_valid` cycles with matching data.
  - With macro undefined, `req_ready=1` one cycle after reset.
